// File: rtl/ibex_multdiv_issue_if.sv
// Decode-side request and writeback-side response handshakes of the multdiv issue controller.
// The slave modport is the controller's view; the master modport is decode/writeback.
interface ibex_multdiv_issue_if #(
  parameter int unsigned CNT_W = 6
) ();
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_operator_i;
  logic [1:0]       req_signed_mode_i;
  logic [31:0]      req_op_a_i;
  logic [31:0]      req_op_b_i;
  logic [4:0]       req_tag_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_result_o;
  logic [4:0]       rsp_tag_o;
  logic [CNT_W-1:0] rsp_cycles_o;

  modport master (
    output req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i, req_tag_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_cycles_o
  );

  modport slave (
    input  req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i, req_tag_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_cycles_o
  );
endinterface

// File: rtl/ibex_multdiv_issue.sv
// Requester-side controller for the multicycle multiply/divide engine: issues one request,
// owns the engine's intermediate registers, and drains the engine on kill since it cannot abort.
module ibex_multdiv_issue #(
  parameter int unsigned IMD_W = 34,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ibex_multdiv_issue_if.slave  io,
  input  logic                 kill_i,
  output logic                 md_mult_en_o,
  output logic                 md_div_en_o,
  output logic                 md_mult_sel_o,
  output logic                 md_div_sel_o,
  output logic [1:0]           md_operator_o,
  output logic [1:0]           md_signed_mode_o,
  output logic [31:0]          md_op_a_o,
  output logic [31:0]          md_op_b_o,
  output logic                 md_ready_id_o,
  output logic [2*IMD_W-1:0]   md_imd_val_q_o,
  input  logic [2*IMD_W-1:0]   md_imd_val_d_i,
  input  logic [1:0]           md_imd_val_we_i,
  input  logic [31:0]          md_result_i,
  input  logic                 md_valid_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, RESP = 2'd3} state_e;

  state_e                state_q, state_d;
  logic [1:0]            operator_q, signed_mode_q;
  logic [31:0]           op_a_q, op_b_q, result_q;
  logic [4:0]            tag_q, rsp_tag_q;
  logic [CNT_W-1:0]      cnt_q, cnt_inc_s;
  logic [1:0][IMD_W-1:0] imd_q;
  logic                  mult_en_q, div_en_q, busy_q, rsp_valid_q;
  logic                  req_ready_s, accept_s, capture_s, engine_on_d, next_mul_s;

  // Request readiness; a response handshake may take the next request in the same cycle
  always_comb begin
    req_ready_s = 1'b0;
    if (rst_i || kill_i) begin
      req_ready_s = 1'b0;
    end else if (state_q == IDLE) begin
      req_ready_s = 1'b1;
    end else if (state_q == RESP) begin
      req_ready_s = io.rsp_ready_i;
    end else begin
      req_ready_s = 1'b0;
    end
  end

  assign accept_s   = io.req_valid_i & req_ready_s;
  assign capture_s  = (state_q == RUN) & md_valid_i & ~kill_i;
  assign cnt_inc_s  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state selection; DRAIN ignores kill because the engine must finish before reuse
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = RUN;
        else          state_d = IDLE;
      end
      RUN: begin
        if (md_valid_i && !kill_i) state_d = RESP;
        else if (md_valid_i)       state_d = IDLE;
        else if (kill_i)           state_d = DRAIN;
        else                       state_d = RUN;
      end
      DRAIN: begin
        if (md_valid_i) state_d = IDLE;
        else            state_d = DRAIN;
      end
      RESP: begin
        if (kill_i)                state_d = IDLE;
        else if (io.rsp_ready_i) begin
          if (accept_s) state_d = RUN;
          else          state_d = IDLE;
        end else                   state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  assign engine_on_d = (state_d == RUN) || (state_d == DRAIN);
  assign next_mul_s  = accept_s ? ~io.req_operator_i[1] : ~operator_q[1];

  // State, registered engine drive, captured response and the engine's intermediate registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      mult_en_q     <= 1'b0;
      div_en_q      <= 1'b0;
      operator_q    <= 2'd0;
      signed_mode_q <= 2'd0;
      op_a_q        <= 32'd0;
      op_b_q        <= 32'd0;
      tag_q         <= 5'd0;
      rsp_tag_q     <= 5'd0;
      result_q      <= 32'd0;
      cnt_q         <= '0;
      imd_q         <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != IDLE);
      rsp_valid_q <= (state_d == RESP);
      mult_en_q   <= engine_on_d & next_mul_s;
      div_en_q    <= engine_on_d & ~next_mul_s;
      if (accept_s) begin
        operator_q    <= io.req_operator_i;
        signed_mode_q <= io.req_signed_mode_i;
        op_a_q        <= io.req_op_a_i;
        op_b_q        <= io.req_op_b_i;
        tag_q         <= io.req_tag_i;
        cnt_q         <= '0;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_inc_s;
      end
      if (capture_s) begin
        result_q  <= md_result_i;
        rsp_tag_q <= tag_q;
      end
      if (md_imd_val_we_i[0]) imd_q[0] <= md_imd_val_d_i[IMD_W-1:0];
      if (md_imd_val_we_i[1]) imd_q[1] <= md_imd_val_d_i[2*IMD_W-1:IMD_W];
    end
  end

  assign io.req_ready_o    = req_ready_s;
  assign io.rsp_valid_o    = rsp_valid_q;
  assign io.rsp_result_o   = result_q;
  assign io.rsp_tag_o      = rsp_tag_q;
  assign io.rsp_cycles_o   = cnt_q;
  assign md_mult_en_o      = mult_en_q;
  assign md_mult_sel_o     = mult_en_q;
  assign md_div_en_o       = div_en_q;
  assign md_div_sel_o      = div_en_q;
  assign md_operator_o     = operator_q;
  assign md_signed_mode_o  = signed_mode_q;
  assign md_op_a_o         = op_a_q;
  assign md_op_b_o         = op_b_q;
  assign md_ready_id_o     = 1'b1;
  assign md_imd_val_q_o    = imd_q;
  assign busy_o            = busy_q;

endmodule

// File: doc/ibex_multdiv_issue.md
Name: ibex_multdiv_issue

Overview:
Requester-side controller for the multicycle slow multiply/divide engine. It accepts one MUL/DIV request from decode over a valid/ready handshake and drives the engine's enable, select, operator and operand inputs until the engine signals valid. It also owns the engine's two 34-bit intermediate-value registers, captures the result and presents it to writeback over a second valid/ready handshake. A kill aborts an in-flight operation by draining the engine back to idle, because the engine has no abort input.

Parameters:
IMD_W, 34, width of each intermediate-value register (engine contract; must stay 34).
CNT_W, 6, width of the saturating busy-cycle counter reported with each response.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  synchronous, active-high reset.
req_valid_i  in  1  decode has a request.
req_ready_o  out  1  request accepted when req_valid_i & req_ready_o.
req_operator_i  in  2  0 MULL, 1 MULH, 2 DIV, 3 REM.
req_signed_mode_i  in  2  bit0 op_a signed, bit1 op_b signed.
req_op_a_i  in  32  operand A.
req_op_b_i  in  32  operand B.
req_tag_i  in  5  destination register tag, returned with the result.
kill_i  in  1  abort any held or in-flight request.
md_mult_en_o  out  1  engine mult enable.
md_div_en_o  out  1  engine div enable.
md_mult_sel_o  out  1  engine mult select.
md_div_sel_o  out  1  engine div select.
md_operator_o  out  2  registered operator.
md_signed_mode_o  out  2  registered signed mode.
md_op_a_o  out  32  registered operand A.
md_op_b_o  out  32  registered operand B.
md_ready_id_o  out  1  engine may release its result.
md_imd_val_q_o  out  68  {imd1, imd0} register contents to the engine.
md_imd_val_d_i  in  68  next intermediate values from the engine.
md_imd_val_we_i  in  2  per-register write enables from the engine.
md_result_i  in  32  engine result.
md_valid_i  in  1  engine result valid this cycle.
busy_o  out  1  state != IDLE.
rsp_valid_o  out  1  result available.
rsp_ready_i  in  1  writeback consumes the result.
rsp_result_o  out  32  captured result.
rsp_tag_o  out  5  tag of the result.
rsp_cycles_o  out  CNT_W  RUN cycles spent on this result, saturating at all-ones.

Behaviour:
- Reset (rst_i high at clock edge), to be applied together with the engine reset:
  - state = IDLE; all outputs 0 except md_ready_id_o = 1.
  - Operand, operator, tag, result, counter and both imd registers cleared to 0.
- States: IDLE, RUN, DRAIN, RESP.
  - md_ready_id_o = 1 in all states.
  - req_ready_o = ~kill_i & (IDLE | (RESP & rsp_ready_i)).
- Request accept: registers operator, signed mode, operands and tag; counter cleared; next state RUN.
- Engine drive in RUN and DRAIN:
  - is_mul = operator[1]==0.
  - md_mult_en_o = md_mult_sel_o = is_mul.
  - md_div_en_o = md_div_sel_o = ~is_mul.
  - In IDLE and RESP all four are 0.
  - Operands and operator stay constant while in RUN/DRAIN.
- imd registers:
  - Register i loads md_imd_val_d_i[34*i +: 34] whenever md_imd_val_we_i[i] = 1, in any state.
  - md_imd_val_q_o = {imd1, imd0}.
- RUN:
  - Counter increments each cycle, saturating.
  - md_valid_i with ~kill_i: capture md_result_i, counter+1 and tag; go to RESP.
  - kill_i without md_valid_i: go to DRAIN.
  - kill_i with md_valid_i: discard the result; go to IDLE.
- DRAIN: keep enables asserted; on md_valid_i discard the result and go to IDLE. kill_i is ignored.
- RESP:
  - rsp_valid_o = 1; result, tag and count held stable until handshake.
  - rsp_ready_i & ~kill_i: with req_valid_i, accept the new request and go to RUN; otherwise go to IDLE.
  - kill_i: drop the response and go to IDLE.
- Latency:
  - Request accepted at edge N; RUN from cycle N+1.
  - md_valid_i in cycle M gives rsp_valid_o from cycle M+1.
  - At least one bubble between responses; there is no result bypass.
- kill_i in IDLE: no effect, and any coincident request is refused.
- Reset mid-RUN or mid-DRAIN: return to IDLE immediately; no response is produced.

Test Plan:
- MULL 7 x 6, signed_mode 0, tag 3 -> one rsp_valid_o pulse-until-ready with result 0x0000002A, tag 3, rsp_cycles_o >= 1.
- MULH signed 0x80000000 x 0x80000000 -> result 0x40000000; MULH unsigned 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV signed 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM signed same operands -> 0xFFFFFFFF; DIV unsigned 0x80000000 / 0 -> 0xFFFFFFFF; REM 5 % 0 -> 5.
- kill_i two cycles after accepting DIV 100/7 -> DRAIN, no rsp_valid_o, busy_o falls when the engine finishes; the next MULL 3 x 5 returns 0x0000000F.
- rsp_ready_i low for 5 cycles after MULL 9 x 9 -> rsp_valid_o, result 0x51 and tag stable, req_ready_o = 0; raise rsp_ready_i with a queued DIV 20/4 -> accepted in the same cycle, later result 5.
- rst_i asserted mid-DIV -> next cycle busy_o = 0, rsp_valid_o = 0, imd registers 0; the following REM 17 % 5 returns 2.
